// File: rtl/gpo_pkg.sv
// gpo_pkg: shared constants for the general-purpose output core.
// Holds the word addresses of the slot register map so the top level
// decode and any future software-facing collateral agree on one source.
package gpo_pkg;

    localparam logic [4:0] ADDR_DATA = 5'd0;  // RW output latch
    localparam logic [4:0] ADDR_SET  = 5'd1;  // W, latch |= wr_data
    localparam logic [4:0] ADDR_CLR  = 5'd2;  // W, latch &= ~wr_data
    localparam logic [4:0] ADDR_TGL  = 5'd3;  // W, latch ^= wr_data
    localparam logic [4:0] ADDR_MASK = 5'd4;  // RW blink mask
    localparam logic [4:0] ADDR_DIV  = 5'd5;  // RW blink half-period minus 1
    localparam logic [4:0] ADDR_PIN  = 5'd6;  // RO current data_out

endpackage

// File: rtl/blink_timer.sv
// blink_timer: half-period counter and phase flip-flop for the blink engine.
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high reset
//   enable  - at least one pin is blinking (mask != 0)
//   div     - half-period length in cycles minus 1
//   restart - divider write strobe; forces a clean restart at this edge
//   phase   - blink phase, XORed onto masked pins by the top level
module blink_timer #(
    parameter int DIV_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             phase
);

    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic             phase_r;
    logic             phase_nxt_s;

    // Next-state: restart and idle share one fixed restart point (cnt 0, phase 0).
    // cnt never exceeds div because div only changes together with a restart.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        phase_nxt_s = phase_r;
        if (restart || !enable) begin
            cnt_nxt_s   = CNT_ZERO;
            phase_nxt_s = 1'b0;
        end else if (cnt_r == div) begin
            cnt_nxt_s   = CNT_ZERO;
            phase_nxt_s = ~phase_r;
        end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            phase_nxt_s = phase_r;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= CNT_ZERO;
            phase_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/gpo_blink.sv
// gpo_blink: memory-mapped general-purpose output core with a per-bit
// hardware blink engine, on the standard MMIO slot interface.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   cs, read, write   - slot select and strobes (write commits at the edge)
//   address           - slot word address (see gpo_pkg for the map)
//   wr_data / rd_data - 32-bit write data / combinational read data
//   data_out          - external pins: latch ^ (mask & phase)
module gpo_blink
    import gpo_pkg::*;
#(
    parameter int             W         = 16,
    parameter int             DIV_W     = 32,
    parameter logic [DIV_W-1:0] RESET_DIV = 32'd49_999_999
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [4:0]   address,
    output logic [31:0]  rd_data,
    input  logic [31:0]  wr_data,
    input  logic         read,
    input  logic         write,
    input  logic         cs,
    output logic [W-1:0] data_out
);

    logic [W-1:0]     latch_r;
    logic [W-1:0]     mask_r;
    logic [DIV_W-1:0] div_r;
    logic             wr_en_s;
    logic             restart_s;
    logic             enable_s;
    logic             phase_s;
    logic [W-1:0]     wr_bits_s;
    logic [W-1:0]     pin_s;
    logic [31:0]      rd_data_s;
    logic             unused_s;

    assign wr_en_s   = cs & write;
    assign wr_bits_s = wr_data[W-1:0];
    assign restart_s = wr_en_s && (address == ADDR_DIV);
    assign enable_s  = |mask_r;

    // read is not needed: rd_data is a free-running mux, so the strobe is ignored.
    assign unused_s = &{1'b0, read, wr_data};

    // Register file: output latch with atomic set/clear/toggle, mask and divider.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_r <= {W{1'b0}};
            mask_r  <= {W{1'b0}};
            div_r   <= RESET_DIV;
        end else if (wr_en_s) begin
            case (address)
                ADDR_DATA: latch_r <= wr_bits_s;
                ADDR_SET:  latch_r <= latch_r | wr_bits_s;
                ADDR_CLR:  latch_r <= latch_r & ~wr_bits_s;
                ADDR_TGL:  latch_r <= latch_r ^ wr_bits_s;
                ADDR_MASK: mask_r  <= wr_bits_s;
                ADDR_DIV:  div_r   <= wr_data[DIV_W-1:0];
                default:   latch_r <= latch_r;
            endcase
        end else begin
            latch_r <= latch_r;
        end
    end

    blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable_s),
        .div     (div_r),
        .restart (restart_s),
        .phase   (phase_s)
    );

    // Pin value: blinking bits are the latch value inverted during phase 1.
    always_comb begin
        pin_s = latch_r ^ (mask_r & {W{phase_s}});
    end

    // Read mux: zero-extended view of current register state (pre-write on a write cycle).
    always_comb begin
        rd_data_s = 32'd0;
        case (address)
            ADDR_DATA: rd_data_s[W-1:0]     = latch_r;
            ADDR_MASK: rd_data_s[W-1:0]     = mask_r;
            ADDR_DIV:  rd_data_s[DIV_W-1:0] = div_r;
            ADDR_PIN:  rd_data_s[W-1:0]     = pin_s;
            default:   rd_data_s            = 32'd0;
        endcase
    end

    assign rd_data  = rd_data_s;
    assign data_out = pin_s;

endmodule
